uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync_fifo.sv | 79 +++++++
 rtl/uart_rx_fifo.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, RX FSM state encoding and baud divisor helper.
// Optional 8E1 parity support is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;
  localparam int unsigned BIT_IDX_W  = $clog2(DATA_BITS);
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_IDLE
  } rx_state_e;
`endif

  // Clocks per oversample tick: (clk + 8*baud) / (16*baud).
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    longint unsigned num;
    longint unsigned den;
    num = 64'(clk_hz) + 64'(8) * 64'(baud);
    den = 64'(16) * 64'(baud);
    return 32'(num / den);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: head-registered first-word-fall-through FIFO.
// Push is accepted when not full or when the head is popped in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  output logic                   full_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, full_q;
  logic             pop_c, push_ok_c;

  // Pointer/occupancy update and next head selection (bypass when the new head is being written).
  always_comb begin
    pop_c     = valid_q & ready_i;
    push_ok_c = push_i & (~full_q | pop_c);
    wr_ptr_d  = push_ok_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    head_d = (push_ok_c && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
      full_q   <= (count_d == CW'(DEPTH));
    end
  end

  assign full_o  = full_q;
  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled 8N1 UART receiver feeding a valid/ready byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 27000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_BITS-1:0]        out_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_fifo: clock too slow for the requested baud (DIV < 1)");
  end

  logic                 rx_meta_q, rx_sync_q;
  rx_state_e            state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick_c;
  logic [TICK_W-1:0]    tcnt_q, tcnt_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push_c;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 fifo_full, fifo_valid;

  assign tick_c = (presc_q == PW'(DIV - 1));

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Frame decoder next-state, prescaler and push/error strobes.
  always_comb begin
    state_d = state_q;
    presc_d = tick_c ? '0 : presc_q + PW'(1);
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push_c  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d = ST_START;
          tcnt_d  = '0;
          presc_d = '0;
        end
      end
      ST_START: begin
        if (tick_c) begin
          tcnt_d = tcnt_q + TICK_W'(1);
          if (tcnt_q == TICK_W'(MID_TICK)) begin
            if (rx_sync_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              tcnt_d  = '0;
              bit_d   = '0;
            end
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          tcnt_d = tcnt_q + TICK_W'(1);
          if (tcnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_IDX_W'(1);
            if (bit_q == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_c) begin
          tcnt_d = tcnt_q + TICK_W'(1);
          if (tcnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            if (rx_sync_q != ^shift_q) begin
              ferr_d  = 1'b1;
              state_d = ST_WAIT_IDLE;
            end else begin
              state_d = ST_STOP;
            end
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick_c) begin
          tcnt_d = tcnt_q + TICK_W'(1);
          if (tcnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            if (rx_sync_q) begin
              push_c  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_WAIT_IDLE;
            end
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_sync_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ovr_d = push_c & fifo_full & ~(fifo_valid & out_ready);
  end

  // Decoder state and error pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tcnt_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (push_c),
    .push_data_i (shift_q),
    .full_o      (fifo_full),
    .valid_o     (fifo_valid),
    .ready_i     (out_ready),
    .data_o      (out_data),
    .count_o     (fifo_count)
  );

  assign out_valid = fifo_valid;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives UART frames on rx and checks the byte stream against a queue model.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ_HZ = 16000000;
  localparam int BAUD        = 1000000;
  localparam int DEPTH       = 16;
  localparam int BIT_CLKS    = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Negedges from driving the start bit to out_valid: 2 sync + 1 edge detect
  // + 8 to start-bit middle + 8 data bits (+ parity bit) + 16 to stop-bit middle.
  localparam int PUSH_VIS = 2 + 1 + 8 + 16 * 8 + (PAR_EN ? 16 : 0) + 16;

  logic       clock, reset, rx, out_ready;
  logic       out_valid, frame_err, overrun;
  logic [7:0] out_data;
  logic [4:0] fifo_count;

  int         checks = 0;
  int         errors = 0;
  int         ferr_seen = 0, ovr_seen = 0, exp_ferr = 0, exp_ovr = 0;
  int         cyc = 0;
  int         rise_cyc = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  int         ready_mode = 0;
  int         force_pop_cyc = -1;

  uart_rx_fifo #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // One clock: count pulses, track out_valid rise, act as consumer and score pops.
  task automatic step();
    logic [7:0] exp;
    @(negedge clock);
    cyc++;
    if (frame_err === 1'b1) ferr_seen++;
    if (overrun === 1'b1) ovr_seen++;
    if (out_valid === 1'b1 && prev_valid !== 1'b1 && rise_cyc < 0) rise_cyc = cyc;
    prev_valid = out_valid;
    case (ready_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
    if (cyc == force_pop_cyc) out_ready = 1'b1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %02h, expected no byte available", out_data);
      end else begin
        exp = exp_q.pop_front();
        if (out_data !== exp) begin
          errors++;
          $display("FAIL pop_data: got %02h, expected %02h", out_data, exp);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  // Drive one frame; the model decides push/drop/error at the stop (or parity) sample.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    logic fbits[$];
    int   nb;
    logic good;
    fbits.push_back(1'b0);
    for (int i = 0; i < 8; i++) fbits.push_back(b[i]);
    if (PAR_EN) fbits.push_back(par_bit);
    fbits.push_back(stop_bit);
    nb   = fbits.size();
    good = stop_bit && (!PAR_EN || (par_bit == ^b));
    rx   = fbits[0];
    for (int k = 1; k <= nb * BIT_CLKS; k++) begin
      step();
      if (k == PUSH_VIS - 1) begin
        if (!good) exp_ferr++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr++;
      end
      if ((k % BIT_CLKS) == 0 && k < nb * BIT_CLKS) rx = fbits[k / BIT_CLKS];
    end
  endtask

  // Pop everything with ready held high, then confirm the FIFO is empty.
  task automatic drain();
    int guard = 0;
    ready_mode = 2;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && guard < 64) begin
      step();
      guard++;
    end
    ready_mode = 0;
    step();
    checks++;
    if (guard >= 64) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes still expected, expected 0", exp_q.size());
    end
    checks++;
    if (fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL drain_count: got %0d, expected 0", fifo_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; out_ready = 1'b0;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", out_data); end
    checks++;
    if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", fifo_count); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
    reset = 1'b0;
    idle(4);
  endtask

  task automatic test_single_byte();
    int start;
    logic [7:0] b;
    b = 8'hA5;
    ready_mode = 0;
    rise_cyc = -1;
    start = cyc;
    drive_frame(b, 1'b1, ^b);
    checks++;
    if (rise_cyc - start != PUSH_VIS) begin
      errors++;
      $display("FAIL a5_latency: got %0d, expected %0d", rise_cyc - start, PUSH_VIS);
    end
    checks++;
    if (out_data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %02h, expected a5", out_data); end
    checks++;
    if (fifo_count !== 5'd1) begin errors++; $display("FAIL a5_count: got %0d, expected 1", fifo_count); end
    checks++;
    if (ferr_seen != 0 || ovr_seen != 0) begin
      errors++;
      $display("FAIL a5_pulses: got ferr=%0d ovr=%0d, expected 0 0", ferr_seen, ovr_seen);
    end
    drain();
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    ready_mode = 0;
    rx = 1'b0;
    repeat (3) step();
    idle(30);
    checks++;
    if (fifo_count !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_count: got count=%0d valid=%b, expected 0 0", fifo_count, out_valid);
    end
    checks++;
    if (ferr_seen != exp_ferr) begin errors++; $display("FAIL glitch_ferr: got %0d, expected %0d", ferr_seen, exp_ferr); end
    b = 8'($urandom);
    drive_frame(b, 1'b1, ^b);
    idle(3);
    drain();
  endtask

  task automatic test_frame_err();
    int f0;
    logic [7:0] b;
    ready_mode = 0;
    f0 = ferr_seen;
    b = 8'h3C;
    drive_frame(b, 1'b0, ^b);
    rx = 1'b0;
    repeat (40) step();
    checks++;
    if (ferr_seen - f0 != 1) begin errors++; $display("FAIL ferr_pulses: got %0d, expected 1", ferr_seen - f0); end
    checks++;
    if (fifo_count !== 5'd0) begin errors++; $display("FAIL ferr_count: got %0d, expected 0", fifo_count); end
    idle(5);
    b = 8'h5A;
    drive_frame(b, 1'b1, ^b);
    idle(2);
    checks++;
    if (out_data !== 8'h5A) begin errors++; $display("FAIL ferr_next_data: got %02h, expected 5a", out_data); end
    drain();
  endtask

  task automatic test_overrun();
    int o0, start;
    logic [7:0] b;
    ready_mode = 0;
    for (int i = 0; i <= 16; i++) begin
      o0 = ovr_seen;
      b = 8'(i);
      drive_frame(b, 1'b1, ^b);
      idle($urandom_range(0, 8));
      checks++;
      if (ovr_seen - o0 != ((i == 16) ? 1 : 0)) begin
        errors++;
        $display("FAIL overrun_byte_%0d: got %0d pulses, expected %0d", i, ovr_seen - o0, (i == 16) ? 1 : 0);
      end
    end
    checks++;
    if (fifo_count !== 5'd16) begin errors++; $display("FAIL overrun_count: got %0d, expected 16", fifo_count); end
    // Full FIFO: pop coincident with the push cycle of one more byte.
    o0 = ovr_seen;
    start = cyc;
    force_pop_cyc = start + PUSH_VIS - 1;
    b = 8'h77;
    drive_frame(b, 1'b1, ^b);
    force_pop_cyc = -1;
    checks++;
    if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_pushpop_count: got %0d, expected 16", fifo_count); end
    checks++;
    if (ovr_seen != o0) begin errors++; $display("FAIL full_pushpop_overrun: got %0d, expected 0", ovr_seen - o0); end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    int f0, o0;
    logic [7:0] b;
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      drive_frame(b, 1'b1, ^b);
      idle(2);
    end
    checks++;
    if (fifo_count !== 5'd4) begin errors++; $display("FAIL midreset_prefill: got %0d, expected 4", fifo_count); end
    b = 8'($urandom);
    rx = 1'b0;
    repeat (BIT_CLKS) step();
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) step();
    end
    reset = 1'b1;
    rx = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL midreset_flush: got valid=%b count=%0d, expected 0 0", out_valid, fifo_count);
    end
    reset = 1'b0;
    exp_q.delete();
    f0 = ferr_seen;
    o0 = ovr_seen;
    idle(40);
    b = 8'h81;
    drive_frame(b, 1'b1, ^b);
    idle(2);
    checks++;
    if (ferr_seen != f0 || ovr_seen != o0) begin
      errors++;
      $display("FAIL midreset_pulses: got ferr=%0d ovr=%0d, expected 0 0", ferr_seen - f0, ovr_seen - o0);
    end
    checks++;
    if (out_data !== 8'h81 || fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL midreset_rx: got data=%02h count=%0d, expected 81 1", out_data, fifo_count);
    end
    drain();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic stop_b, par_b;
    ready_mode = 1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      stop_b = 1'b1;
      par_b = ^b;
      if ($urandom_range(0, 4) == 0) begin
        if (PAR_EN && $urandom_range(0, 1) == 1) par_b = ~par_b;
        else stop_b = 1'b0;
      end
      drive_frame(b, stop_b, par_b);
      idle($urandom_range(2, 10));
    end
    drain();
    checks++;
    if (ferr_seen != exp_ferr) begin errors++; $display("FAIL random_ferr: got %0d, expected %0d", ferr_seen, exp_ferr); end
    checks++;
    if (ovr_seen != exp_ovr) begin errors++; $display("FAIL random_overrun: got %0d, expected %0d", ovr_seen, exp_ovr); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int f0;
    ready_mode = 0;
    f0 = ferr_seen;
    drive_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (ferr_seen - f0 != 1 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL parity_bad: got ferr=%0d count=%0d, expected 1 0", ferr_seen - f0, fifo_count);
    end
    drive_frame(8'h07, 1'b1, 1'b1);
    idle(2);
    checks++;
    if (out_data !== 8'h07 || fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL parity_good: got data=%02h count=%0d, expected 07 1", out_data, fifo_count);
    end
    drain();
  endtask
`endif

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    out_ready = 1'b0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
